// File: rtl/pc_tt_pkg.sv
// pc_target_table shared types: default targets, FSM states, entry layout.
// Defaults are 32-bit signed and are truncated to the table width on use.
package pc_tt_pkg;

  localparam int N_DEFAULTS = 8;

  localparam logic signed [31:0] DEFAULT_TGT [N_DEFAULTS] = '{
    32'sd2, 32'sd3, 32'sd22, -32'sd26,
    32'sd130, -32'sd132, 32'sd162, -32'sd168
  };

  typedef enum logic {
    IDLE,
    RESTORE
  } state_t;

  typedef struct packed {
    logic               abs;
    logic signed [31:0] offset;
  } tt_entry_t;

  function automatic tt_entry_t default_entry(int unsigned idx);
    tt_entry_t e;
    e.abs    = 1'b0;
    e.offset = (idx < N_DEFAULTS) ? DEFAULT_TGT[idx[2:0]] : '0;
    return e;
  endfunction

endpackage

// File: rtl/pc_tt_adder.sv
// Combinational next-PC: pc+1, absolute target, or pc+offset mod 2^D.
// wrap flags a modular wrap of the relative add or of the increment.
module pc_tt_adder #(
  parameter int D = 12
) (
  input  logic [D-1:0] pc,
  input  logic [D-1:0] entry,
  input  logic         abs,
  input  logic         taken,
  output logic [D-1:0] next_pc,
  output logic         wrap
);

  logic [D:0] sum_inc;
  logic [D:0] sum_rel;

  assign sum_inc = {1'b0, pc} + {{D{1'b0}}, 1'b1};
  assign sum_rel = {1'b0, pc} + {1'b0, entry};

  // Negative offsets wrap when the unsigned add does not carry.
  always_comb begin
    next_pc = sum_inc[D-1:0];
    wrap    = sum_inc[D];
    unique case (1'b1)
      !taken: begin
        next_pc = sum_inc[D-1:0];
        wrap    = sum_inc[D];
      end
      taken && abs: begin
        next_pc = entry;
        wrap    = 1'b0;
      end
      taken && !abs: begin
        next_pc = sum_rel[D-1:0];
        wrap    = sum_rel[D] ^ entry[D-1];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_target_table.sv
// Programmable branch-target table with registered next-PC output
// and a sequential restore-to-defaults walk.
module pc_target_table
  import pc_tt_pkg::*;
#(
  parameter int D         = 12,
  parameter int N_ENTRIES = 8,
  parameter int IDX_W     = $clog2(N_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [IDX_W-1:0] req_idx,
  input  logic             req_taken,
  input  logic [D-1:0]     pc_in,
  output logic             tgt_valid,
  output logic [D-1:0]     next_pc,
  output logic             pc_wrap,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [D-1:0]     wr_data,
  input  logic             wr_abs,
  input  logic             restore_req,
  output logic             busy
);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] cnt, cnt_nxt;

  logic [D-1:0] ent_off [N_ENTRIES];
  logic         ent_abs [N_ENTRIES];

  logic         idle, accept;
  logic         req_in, wr_in, wr_ok, wr_hit;
  logic [D-1:0] lk_off, sum;
  logic         lk_abs, sum_wrap;

  function automatic logic [D:0] dflt(int unsigned i);
    tt_entry_t e;
    e = default_entry(i);
    return {e.abs, D'(e.offset)};
  endfunction

  assign idle      = (state == IDLE);
  assign req_ready = idle;
  assign busy      = !idle;
  assign accept    = req_valid && idle;

  assign req_in = {1'b0, req_idx} < (IDX_W+1)'(N_ENTRIES);
  assign wr_in  = {1'b0, wr_idx} < (IDX_W+1)'(N_ENTRIES);
  assign wr_ok  = wr_en && idle && wr_in;
  assign wr_hit = wr_ok && (wr_idx == req_idx);

  assign lk_off = wr_hit ? wr_data : ent_off[req_idx];
  assign lk_abs = wr_hit ? wr_abs : ent_abs[req_idx];

  // Out-of-range lookups degrade to the not-taken increment.
  pc_tt_adder #(.D(D)) u_add (
    .pc      (pc_in),
    .entry   (lk_off),
    .abs     (lk_abs),
    .taken   (req_taken && req_in),
    .next_pc (sum),
    .wrap    (sum_wrap)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (restore_req) begin
          state_nxt = RESTORE;
          cnt_nxt   = '0;
        end
      end
      RESTORE: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == IDX_W'(N_ENTRIES - 1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ENTRIES; i++)
        {ent_abs[i], ent_off[i]} <= dflt(i);
    end else if (!idle) begin
      {ent_abs[cnt], ent_off[cnt]} <= dflt(32'(cnt));
    end else if (wr_ok) begin
      ent_abs[wr_idx] <= wr_abs;
      ent_off[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_valid <= 1'b0;
      next_pc   <= '0;
      pc_wrap   <= 1'b0;
    end else begin
      tgt_valid <= accept;
      if (accept) begin
        next_pc <= sum;
        pc_wrap <= sum_wrap;
      end
    end
  end

endmodule

// File: doc/pc_target_table.md
# pc_target_table

Programmable branch-target table for the fetch stage: stores N signed D-bit branch offsets, each tagged relative or absolute, and produces a registered next-PC one cycle after a lookup. It replaces the fixed combinational target lookup. Entries reset to the architectural default targets, can be rewritten at run time, and can be restored to defaults by a sequential restore walk. Sits between the branch-decode logic and the PC register.

## Interface

- `D`, 12: PC / offset width in bits.
- `N_ENTRIES`, 8: number of table entries, ≥2.
- `IDX_W`, $clog2(N_ENTRIES): index width (derived).
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: lookup request this cycle.
- `req_ready` output 1: table accepts lookups; low during restore.
- `req_idx` input IDX_W: entry to look up.
- `req_taken` input 1: branch taken; when 0 the result is pc_in+1.
- `pc_in` input D: PC of the branch instruction.
- `tgt_valid` output 1: next_pc valid (registered).
- `next_pc` output D: computed next PC (registered).
- `pc_wrap` output 1: relative add wrapped modulo 2^D (registered).
- `wr_en` input 1: write entry.
- `wr_idx` input IDX_W: entry to write.
- `wr_data` input D: offset or absolute target.
- `wr_abs` input 1: 1 = absolute entry, 0 = relative.
- `restore_req` input 1: start the restore-defaults walk.
- `busy` output 1: restore in progress.

## Operation

- Defaults, entries 0..7: 2, 3, 22, -26, 130, -132, 162, -168, all relative. Entries ≥8 default to 0, relative. Defaults are 32-bit signed integers truncated to D bits.
- Lookup is accepted when req_valid && req_ready. Next cycle: tgt_valid=1 and next_pc is set as follows:
  - req_taken=0: pc_in+1.
  - Taken, absolute entry: the entry value.
  - Taken, relative entry: (pc_in + entry) mod 2^D.
- pc_wrap=1 only for a taken relative lookup where the unsigned D-bit sum carries, for a non-negative offset, or does not carry, for a negative offset. pc_in+1 overflow also sets pc_wrap.
- Idle cycle (no accepted request): tgt_valid=0; next_pc and pc_wrap hold their last values.
- Write: wr_en in IDLE updates the entry and mode on the edge. A write and a lookup to the same index in the same cycle are write-first: the lookup uses wr_data/wr_abs.
- Out-of-range indices (≥N_ENTRIES, non-power-of-2 depth): lookup returns pc_in+1 with pc_wrap per that add; the write is dropped.
- FSM IDLE/RESTORE:
  - IDLE→RESTORE on restore_req, with count=0.
  - In RESTORE, each cycle writes default[count] and increments count.
  - After writing entry N_ENTRIES-1, returns to IDLE.
  - busy=1 and req_ready=0 exactly while in RESTORE.
- During RESTORE, wr_en and restore_req are ignored and req_valid is not accepted; the requester holds.

## Timing

- Lookup latency is 1 cycle. Throughput is one lookup per cycle in IDLE.
- Restore takes N_ENTRIES cycles. req_ready returns high on the cycle after the last default write.
- Reset, asynchronous and effective immediately, including mid-restore:
  - All entries take their defaults.
  - FSM=IDLE, count=0.
  - tgt_valid=0, next_pc=0, pc_wrap=0, busy=0, req_ready=1.
- restore_req and wr_en in the same IDLE cycle: the write lands first, then the restore overwrites it.
- A lookup accepted in the same cycle as restore_req completes normally with pre-restore contents.

## Structure

- Package pc_tt_pkg holds:
  - the default-target constant array (8 × 32-bit signed);
  - the state enum {IDLE, RESTORE};
  - the entry struct {abs, offset}.
- Sub-module pc_tt_adder: combinational D-bit next-PC computation. Inputs are pc, entry, abs and taken; outputs are next_pc and wrap.
- The top level holds the entry storage (flops), the FSM/counter and the output registers.

## Test plan

- Reset, then taken lookup idx 3 with pc_in=100 → next cycle tgt_valid=1, next_pc=74, pc_wrap=0.
- D=12, taken idx 5 with pc_in=50 → next_pc=4014 (50-132 mod 4096), pc_wrap=1. Not-taken with pc_in=4095 → next_pc=0, pc_wrap=1.
- Write idx 2 = 0x300 absolute together with a same-cycle lookup of idx 2 at pc_in=7 → next_pc=0x300. Later lookup of idx 2 → 0x300.
- Write idx 0 = 40 relative, then restore_req:
  - busy is high for 8 cycles and req_ready is low.
  - A held lookup is accepted on the first IDLE cycle.
  - idx 0 at pc_in=10 → next_pc=12.
- Assert rst_n low on the 4th restore cycle, after overwriting idx 6 → immediately busy=0 and tgt_valid=0. After release, the table holds all defaults.
- N_ENTRIES=12: lookup idx 10 at pc_in=5 → next_pc=5. Lookup idx 15 (out of range) → next_pc=pc_in+1, and a write to idx 15 has no effect.
